// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//
// Purpose:
//   Pulls words from a synchronous FIFO with a one-cycle registered read port
//   and presents them on a valid/ready stream. A 2-entry skid buffer plus a
//   one-bit "inflight" flag absorbs the FIFO read latency. This lets the block
//   sustain one word per cycle without ever dropping a word that was already
//   requested.
//
// Optional feature:
//   FIFO_RD_CNT_EN - when defined, adds the xfer_count output, a 16-bit
//                    wrapping count of words handed downstream.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   asynchronous reset, active low
//   fifo_empty  in   FIFO empty flag
//   fifo_rd_en  out  FIFO pop request (combinational)
//   fifo_data   in   FIFO read data, valid the cycle after an accepted pop
//   m_valid     out  downstream word available (registered)
//   m_ready     in   downstream accepts word
//   m_data      out  downstream word (registered head entry)
//   xfer_count  out  [FIFO_RD_CNT_EN only] words delivered, wraps at 16 bits
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  input  logic [N-1:0] fifo_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] m_data
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]  xfer_count
`endif
);

  // Skid buffer occupancy encoding
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] TWO   = 2'b10;

  logic [1:0]   occ_q, occ_d;
  logic         inflight_q, inflight_d;
  logic         valid_q, valid_d;
  logic [N-1:0] buf0_q, buf0_d;   // head entry, drives m_data
  logic [N-1:0] buf1_q, buf1_d;   // second entry

  logic         pop_s;
  logic         accept_s;
  logic         rd_en_s;
  logic [1:0]   occ_num_s;
  logic [2:0]   level_s;

  assign pop_s = valid_q & m_ready;

  // Decode occupancy state into a numeric word count
  always_comb begin
    occ_num_s = 2'd0;
    case (occ_q)
      EMPTY:   occ_num_s = 2'd0;
      ONE:     occ_num_s = 2'd1;
      TWO:     occ_num_s = 2'd2;
      default: occ_num_s = 2'd0;
    endcase
  end

  // Words held or owed after this edge's pop; pop implies occ >= 1, so no underflow
  assign level_s = {1'b0, occ_num_s} + {2'b00, inflight_q} - {2'b00, pop_s};

  // Only request when the buffer is guaranteed room for the returning word.
  // Gating with reset keeps the request low while reset is held.
  assign rd_en_s    = reset & ~fifo_empty & (level_s < 3'd2);
  assign accept_s   = rd_en_s & ~fifo_empty;
  assign fifo_rd_en = rd_en_s;

  // Next-state for skid buffer: pop shifts entry 1 to head, capture fills the tail
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({pop_s, inflight_q})
      2'b10: begin
        buf0_d = buf1_q;
        occ_d  = (occ_q == TWO) ? ONE : EMPTY;
      end
      2'b01: begin
        case (occ_q)
          EMPTY: begin
            buf0_d = fifo_data;
            occ_d  = ONE;
          end
          ONE: begin
            buf1_d = fifo_data;
            occ_d  = TWO;
          end
          default: occ_d = occ_q;
        endcase
      end
      2'b11: begin
        // Simultaneous pop and capture: occupancy unchanged, order kept
        if (occ_q == TWO) begin
          buf0_d = buf1_q;
          buf1_d = fifo_data;
        end else begin
          buf0_d = fifo_data;
        end
      end
      default: occ_d = occ_q;
    endcase
    inflight_d = accept_s;
    valid_d    = (occ_d != EMPTY);
  end

  // Skid buffer and inflight state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q      <= EMPTY;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = buf0_q;

`ifdef FIFO_RD_CNT_EN
  logic [15:0] count_q, count_d;

  // Transfer count next-state, wraps naturally at 16 bits
  always_comb begin
    if (pop_s) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Transfer count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign xfer_count = count_q;
`endif

endmodule
